// File: rtl/cla_add_arbiter.sv
// ---------------------------------------------------------------------------
// cla_add_arbiter
//
// Purpose:
//   Shares one pipelined N-bit carry-lookahead adder among R requesters.
//   A combinational round-robin arbiter picks at most one requester per
//   cycle and drives its operands onto the adder. A tag pipeline that is
//   LAT entries deep carries the winner's ID alongside the adder. This
//   pipeline routes each sum back to the requester that issued it.
//
// Optional build macro:
//   CLA_ARB_FIXED_PRIO_EN - when defined, the round-robin pointer is removed
//                           and the lowest asserted index always wins.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req_valid  in   [R]      per-requester operation valid
//   req_ready  out  [R]      per-requester accept, one-hot or zero
//   req_a      in   [R*N]    operand A, requester i at [i*N +: N]
//   req_b      in   [R*N]    operand B, same packing
//   add_a      out  [N]      operand A to adder (zero when idle)
//   add_b      out  [N]      operand B to adder (zero when idle)
//   add_sum    in   [N+1]    adder result, LAT cycles after operands
//   rsp_valid  out  [R]      one-hot single-cycle result strobe
//   rsp_id     out  [IDW]    requester ID of the current result
//   rsp_sum    out  [N+1]    registered copy of add_sum
//   busy       out           any tag in flight or a response is showing
// ---------------------------------------------------------------------------
module cla_add_arbiter #(
    parameter int N   = 4,
    parameter int R   = 4,
    parameter int LAT = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [R-1:0]       req_valid,
    output logic [R-1:0]       req_ready,
    input  logic [R*N-1:0]     req_a,
    input  logic [R*N-1:0]     req_b,
    output logic [N-1:0]       add_a,
    output logic [N-1:0]       add_b,
    input  logic [N:0]         add_sum,
    output logic [R-1:0]       rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [N:0]         rsp_sum,
    output logic               busy
);

    logic               found;      // a transfer happens this cycle
    logic [IDW-1:0]     win;        // index of the winning requester
    logic [IDW-1:0]     scan_sel;

    logic [LAT-1:0]     tag_valid_reg;
    logic [IDW-1:0]     tag_id_reg [LAT];

    logic [R-1:0]       rsp_valid_reg;
    logic [R-1:0]       rsp_valid_next;
    logic [IDW-1:0]     rsp_id_reg;
    logic [N:0]         rsp_sum_reg;

`ifndef CLA_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     rr_ptr_reg;
`endif

    // Arbitration: scan from the slot after the last winner (round-robin)
    // or from index 0 (fixed priority). The first asserted request wins.
    // Reset gates the result so no grant or operand leaks out during reset.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_sel = '0;
        for (int k = 0; k < R; k++) begin
`ifdef CLA_ARB_FIXED_PRIO_EN
            scan_sel = IDW'(k);
`else
            scan_sel = IDW'((int'(rr_ptr_reg) + 1 + k) % R);
`endif
            if (!found && req_valid[scan_sel]) begin
                found = 1'b1;
                win   = scan_sel;
            end
        end
        found = found & reset;
    end

    assign add_a = found ? req_a[win*N +: N] : '0;
    assign add_b = found ? req_b[win*N +: N] : '0;

    // One-hot decodes: the grant for this cycle, and the response strobe for
    // the tag that leaves the pipeline this cycle.
    for (genvar gi = 0; gi < R; gi++) begin : g_decode
        assign req_ready[gi]      = found && (win == IDW'(gi));
        assign rsp_valid_next[gi] = tag_valid_reg[LAT-1] &&
                                    (tag_id_reg[LAT-1] == IDW'(gi));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifndef CLA_ARB_FIXED_PRIO_EN
            rr_ptr_reg    <= IDW'(R-1);   // first scan starts at index 0
`endif
            tag_valid_reg <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id_reg[k] <= '0;
            end
            rsp_valid_reg <= '0;
            rsp_id_reg    <= '0;
            rsp_sum_reg   <= '0;
        end else begin
`ifndef CLA_ARB_FIXED_PRIO_EN
            if (found) begin
                rr_ptr_reg <= win;
            end
`endif
            // Tag pipeline runs in lockstep with the adder and never stalls.
            tag_valid_reg[0] <= found;
            tag_id_reg[0]    <= win;
            for (int k = 1; k < LAT; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_id_reg[k]    <= tag_id_reg[k-1];
            end

            rsp_valid_reg <= rsp_valid_next;
            // ID and sum hold their last value between results.
            if (tag_valid_reg[LAT-1]) begin
                rsp_id_reg  <= tag_id_reg[LAT-1];
                rsp_sum_reg <= add_sum;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign busy      = (|tag_valid_reg) | (|rsp_valid_reg);

endmodule
